// File: rtl/result_collector_if.sv
// Output stream of the result collector: one result word per accepted
// valid/ready handshake, tagged with its core and register index.
interface result_collector_if #(
  parameter int DATA_W = 12,
  parameter int CW     = 1,
  parameter int RW     = 4
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     out_core;
  logic [RW-1:0]     out_idx;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_core, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_core, out_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/result_collector.sv
// Multi-core result collector. Snapshots each core's result registers on the
// rising edge of its done level, then streams the words out one per handshake.
//
// state  | meaning
// IDLE   | nothing pending, output idle
// SCAN   | pick the lowest-index pending core, reset the word index
// STREAM | present shadow[cur][idx] until the last word is accepted
module result_collector #(
  parameter int N_CORES = 2,
  parameter int N_REGS  = 16,
  parameter int DATA_W  = 12
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_CORES-1:0]                core_done,
  input  logic [N_CORES*N_REGS*DATA_W-1:0]  core_regs,
  result_collector_if.master                bus,
  output logic                              busy,
  output logic                              all_done,
  output logic                              overrun
);

  localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int RW = $clog2(N_REGS);

  typedef enum logic [1:0] {IDLE, SCAN, STREAM} state_t;

  state_t            state, state_nxt;
  logic              armed;
  logic [N_CORES-1:0] done_q;
  logic [N_CORES-1:0] rise;
  logic [N_CORES-1:0] capture;
  logic [N_CORES-1:0] pending;
  logic [N_CORES-1:0] streamed;
  logic [N_CORES-1:0] cur_oh;
  logic [N_CORES-1:0] clear_oh;
  logic [CW-1:0]     cur;
  logic [CW-1:0]     low_idx;
  logic [RW-1:0]     idx;
  logic              last;
  logic              accept;
  logic              other_pending;
  logic              streaming;
  logic [DATA_W-1:0] shadow [N_CORES][N_REGS];

  // The first cycle after reset only loads done_q, so a done level held
  // high across reset must fall and rise again before it counts.
  assign rise          = armed ? (core_done & ~done_q) : '0;
  assign capture       = rise & ~pending;
  assign streaming     = (state == STREAM);
  assign last          = (idx == RW'(N_REGS - 1));
  assign accept        = streaming & bus.out_ready;
  assign clear_oh      = (accept && last) ? cur_oh : '0;
  assign other_pending = |(pending & ~cur_oh);

  // One-hot decode of the core currently being streamed.
  always_comb begin
    cur_oh = '0;
    for (int c = 0; c < N_CORES; c++) begin
      cur_oh[c] = (CW'(c) == cur);
    end
  end

  // Lowest-index pending core, used when SCAN latches the next core.
  always_comb begin
    low_idx = '0;
    for (int c = N_CORES - 1; c >= 0; c--) begin
      if (pending[c]) low_idx = CW'(c);
    end
  end

  // Done edge detector and post-reset arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
      armed  <= 1'b0;
    end else begin
      done_q <= core_done;
      armed  <= 1'b1;
    end
  end

  // Shadow buffer: a whole core slice is taken in the capture cycle.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CORES; c++) begin
      if (capture[c]) begin
        for (int i = 0; i < N_REGS; i++) begin
          shadow[c][i] <= core_regs[(c*N_REGS+i)*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Pending/streamed bookkeeping and sticky status flags.
  // Pending is checked before the last-word clear, so a rise coinciding
  // with the final acceptance of that core counts as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      streamed <= '0;
      overrun  <= 1'b0;
      all_done <= 1'b0;
    end else begin
      pending  <= (pending & ~clear_oh) | capture;
      streamed <= streamed | clear_oh;
      overrun  <= overrun | (|(rise & pending));
      all_done <= all_done | (&streamed);
    end
  end

  // Current core and word index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
      idx <= '0;
    end else if (state == SCAN) begin
      cur <= low_idx;
      idx <= '0;
    end else if (accept && !last) begin
      idx <= idx + RW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pending) state_nxt = SCAN;
      SCAN:    state_nxt = STREAM;
      STREAM:  if (accept && last) state_nxt = other_pending ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output stream; fields are forced to zero outside STREAM so reset and
  // idle never expose stale shadow contents.
  always_comb begin
    bus.out_valid = streaming;
    bus.out_data  = streaming ? shadow[cur][idx] : '0;
    bus.out_core  = streaming ? cur : '0;
    bus.out_idx   = streaming ? idx : '0;
    bus.out_last  = streaming & last;
    busy          = (state != IDLE);
  end

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: stimulus pushes expected words
// into a scoreboard queue, a negedge monitor pops and compares accepted words.
module tb_result_collector;
  localparam int N_CORES = 2;
  localparam int N_REGS  = 16;
  localparam int DATA_W  = 12;
  localparam int CW      = 1;
  localparam int RW      = 4;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CW-1:0]     core;
    logic [RW-1:0]     idx;
    logic              last;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [N_CORES-1:0] core_done;
  logic [N_CORES*N_REGS*DATA_W-1:0] core_regs;
  logic busy, all_done, overrun;

  result_collector_if #(.DATA_W(DATA_W), .CW(CW), .RW(RW)) bus ();

  result_collector #(.N_CORES(N_CORES), .N_REGS(N_REGS), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core_done (core_done),
    .core_regs (core_regs),
    .bus       (bus),
    .busy      (busy),
    .all_done  (all_done),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  int   acc_cnt = 0;
  exp_t exp_q[$];
  logic bp_mode = 1'b0;
  logic ready_level = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Single driver of out_ready: either a level or the 1,0,0 stall pattern.
  initial begin
    int ph;
    ph = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        bus.out_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        bus.out_ready = ready_level;
      end
    end
  end

  // Monitor: stall stability plus scoreboard compare on each acceptance.
  logic prev_stall = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      exp_q.delete();
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data",  32'(bus.out_data),  32'(held.data));
        check("hold_core",  32'(bus.out_core),  32'(held.core));
        check("hold_idx",   32'(bus.out_idx),   32'(held.idx));
        check("hold_last",  32'(bus.out_last),  32'(held.last));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_word: got data 0x%0h core %0d idx %0d, expected no word",
                   bus.out_data, bus.out_core, bus.out_idx);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 32'(bus.out_data), 32'(e.data));
          check("word_core", 32'(bus.out_core), 32'(e.core));
          check("word_idx",  32'(bus.out_idx),  32'(e.idx));
          check("word_last", 32'(bus.out_last), 32'(e.last));
        end
        acc_cnt++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held.data  = bus.out_data;
      held.core  = bus.out_core;
      held.idx   = bus.out_idx;
      held.last  = bus.out_last;
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_regs(input int c, input int base, input int step);
    for (int i = 0; i < N_REGS; i++)
      core_regs[(c*N_REGS+i)*DATA_W +: DATA_W] = DATA_W'(base + step*i);
  endtask

  task automatic push_core(input int c, input int base);
    exp_t e;
    for (int i = 0; i < N_REGS; i++) begin
      e.data = DATA_W'(base + i);
      e.core = CW'(c);
      e.idx  = RW'(i);
      e.last = (i == N_REGS - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 400) begin
      n_total++;
      $display("FAIL %s_timeout: got %0d words left, expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    core_done = '0;
    core_regs = '0;
    #7;
    check("rst_valid",    32'(bus.out_valid), 32'd0);
    check("rst_busy",     32'(busy),          32'd0);
    check("rst_all_done", 32'(all_done),      32'd0);
    check("rst_overrun",  32'(overrun),       32'd0);
    check("rst_data",     32'(bus.out_data),  32'd0);
    wait_edges(2);
    rst_n = 1'b1;
    ready_level = 1'b1;
    wait_edges(3);

    // Single core, ready held high: exact latency and dump length.
    set_regs(0, 1, 1);
    push_core(0, 1);
    base = acc_cnt;
    core_done[0] = 1'b1;
    wait_edges(1);
    check("t1_k_valid", 32'(bus.out_valid), 32'd0);
    check("t1_k_busy",  32'(busy),          32'd0);
    wait_edges(1);
    check("t1_scan_valid", 32'(bus.out_valid), 32'd0);
    check("t1_scan_busy",  32'(busy),          32'd1);
    wait_edges(1);
    check("t1_first_valid", 32'(bus.out_valid), 32'd1);
    check("t1_first_data",  32'(bus.out_data),  32'd1);
    wait_edges(15);
    check("t1_last_busy", 32'(busy),          32'd1);
    check("t1_last_flag", 32'(bus.out_last),  32'd1);
    check("t1_last_data", 32'(bus.out_data),  32'd16);
    wait_edges(1);
    check("t1_end_busy",  32'(busy), 32'd0);
    check("t1_count",     32'(acc_cnt - base), 32'd16);
    check("t1_all_done",  32'(all_done), 32'd0);

    // Backpressure: ready pattern 1,0,0.
    core_done[0] = 1'b0;
    wait_edges(2);
    set_regs(0, 'h30, 1);
    push_core(0, 'h30);
    base = acc_cnt;
    bp_mode = 1'b1;
    core_done[0] = 1'b1;
    drain("t2");
    bp_mode = 1'b0;
    wait_edges(2);
    check("t2_count", 32'(acc_cnt - base), 32'd16);

    // Simultaneous done on both cores.
    core_done = '0;
    wait_edges(2);
    set_regs(0, 'h100, 1);
    set_regs(1, 'h200, 1);
    push_core(0, 'h100);
    push_core(1, 'h200);
    base = acc_cnt;
    core_done = 2'b11;
    wait_edges(19);
    check("t3_gap_valid", 32'(bus.out_valid), 32'd0);
    check("t3_gap_busy",  32'(busy),          32'd1);
    wait_edges(1);
    check("t3_c1_valid", 32'(bus.out_valid), 32'd1);
    check("t3_c1_core",  32'(bus.out_core),  32'd1);
    check("t3_c1_idx",   32'(bus.out_idx),   32'd0);
    wait_edges(16);
    check("t3_all_done_pre", 32'(all_done), 32'd0);
    wait_edges(1);
    check("t3_all_done",  32'(all_done), 32'd1);
    check("t3_count",     32'(acc_cnt - base), 32'd32);

    // Snapshot isolation: regs change right after capture.
    core_done[0] = 1'b0;
    wait_edges(2);
    set_regs(0, 'h400, 1);
    push_core(0, 'h400);
    core_done[0] = 1'b1;
    wait_edges(1);
    set_regs(0, 'hFFF, -1);
    drain("t4");

    // Overrun: second rise while the snapshot is still pending.
    ready_level = 1'b0;
    core_done[0] = 1'b0;
    wait_edges(2);
    set_regs(0, 'h500, 1);
    push_core(0, 'h500);
    base = acc_cnt;
    core_done[0] = 1'b1;
    wait_edges(5);
    check("t5_pre_overrun", 32'(overrun), 32'd0);
    core_done[0] = 1'b0;
    set_regs(0, 'h777, 0);
    wait_edges(1);
    core_done[0] = 1'b1;
    wait_edges(1);
    check("t5_overrun", 32'(overrun), 32'd1);
    ready_level = 1'b1;
    drain("t5");
    wait_edges(20);
    check("t5_count",   32'(acc_cnt - base), 32'd16);
    check("t5_idle",    32'(busy), 32'd0);
    check("t5_sticky",  32'(overrun), 32'd1);

    // Reset after the 5th accepted word.
    core_done[0] = 1'b0;
    wait_edges(2);
    set_regs(0, 'h600, 1);
    push_core(0, 'h600);
    base = acc_cnt;
    core_done[0] = 1'b1;
    wait_edges(8);
    rst_n = 1'b0;
    #1;
    check("t6_accepted", 32'(acc_cnt - base), 32'd5);
    check("t6_rst_valid",    32'(bus.out_valid), 32'd0);
    check("t6_rst_data",     32'(bus.out_data),  32'd0);
    check("t6_rst_idx",      32'(bus.out_idx),   32'd0);
    check("t6_rst_last",     32'(bus.out_last),  32'd0);
    check("t6_rst_busy",     32'(busy),          32'd0);
    check("t6_rst_overrun",  32'(overrun),       32'd0);
    check("t6_rst_all_done", 32'(all_done),      32'd0);
    wait_edges(3);
    rst_n = 1'b1;
    base = acc_cnt;
    wait_edges(10);
    check("t6_held_valid", 32'(bus.out_valid), 32'd0);
    check("t6_held_busy",  32'(busy),          32'd0);
    check("t6_held_count", 32'(acc_cnt - base), 32'd0);
    core_done[0] = 1'b0;
    wait_edges(2);
    set_regs(0, 'h700, 1);
    push_core(0, 'h700);
    core_done[0] = 1'b1;
    drain("t6");
    wait_edges(2);
    check("t6_count",    32'(acc_cnt - base), 32'd16);
    check("t6_all_done", 32'(all_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Multi-core successor to the single-core result readout. The single-core flow exposes 16 fixed 12-bit result registers plus end_process. This block generalises that to N_CORES cores, N_REGS registers and DATA_W bits.
- On each core's done rising edge, the block snapshots that core's result registers into a shadow buffer. It then streams the words out one per accepted handshake, tagged with core and register index.
- Sits between the core array and the host/UART dump path.
- Replaces bench-side polling of end_process.

Parameters:
- N_CORES, 2, number of cores monitored (1..16)
- N_REGS, 16, result registers per core (2..64)
- DATA_W, 12, result register width
- Derived: CW = max(1, clog2(N_CORES)), RW = clog2(N_REGS)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_done  in  N_CORES  per-core end_process level; bit c is core c
- core_regs  in  N_CORES*N_REGS*DATA_W  flattened results; word (c*N_REGS+i) is core c, register i (r(i+1))
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- out_data  out  DATA_W  result word
- out_core  out  CW  core index of out_data
- out_idx  out  RW  register index of out_data (0 = r1)
- out_last  out  1  high with the final word (idx N_REGS-1) of a core
- busy  out  1  high in SCAN or STREAM
- all_done  out  1  sticky; every core captured and fully streamed since reset
- overrun  out  1  sticky; a done edge arrived while that core's snapshot was still pending

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0.
  - pending, streamed and done_q vectors are cleared and the FSM enters IDLE.
  - Shadow buffer contents are don't-care.
  - Reset mid-stream aborts immediately; no partial word is re-emitted after release.
- Edge detect: done_q <= core_done each cycle; rise[c] = core_done[c] & ~done_q[c]. A level held high produces exactly one capture.
- Capture: on a clock edge with rise[c] and pending[c]==0:
  - shadow[c] <= core_regs slice c (all N_REGS words in that same cycle);
  - pending[c] <= 1.
- Overrun: rise[c] with pending[c]==1 sets overrun. The new data is discarded and the existing snapshot is kept intact.
- Multiple cores may rise in the same cycle; each is captured independently.
- FSM:
  - IDLE: if any pending, go to SCAN.
  - SCAN (1 cycle): latch cur = lowest-index pending core, set idx = 0, go to STREAM.
  - STREAM: out_valid=1, out_data=shadow[cur][idx], out_core=cur, out_idx=idx, out_last=(idx==N_REGS-1).
    - On out_valid & out_ready with out_last=0: idx++.
    - On out_valid & out_ready with out_last=1: pending[cur] <= 0, streamed[cur] <= 1, then go to SCAN if any other core is pending, else IDLE.
- Handshake:
  - While out_valid & ~out_ready, out_data, out_core, out_idx and out_last are held stable.
  - out_valid never drops before acceptance.
  - No combinational path from out_ready to out_valid.
- Latency: a rise sampled at edge k is captured at k; SCAN occupies k+1; the first word is valid after edge k+2. With out_ready held high, a core's dump takes N_REGS cycles. Consecutive pending cores are separated by one SCAN cycle.
- Same-core hazards:
  - A rise for cur during STREAM while pending[cur]=1 is an overrun.
  - A rise in the same cycle as the last-word acceptance of cur is also an overrun (pending is checked before the clear).
- busy = (state != IDLE).
- all_done is set the cycle after streamed becomes all-ones and remains set until reset.
- Arithmetic: idx is an RW-bit counter that never wraps past N_REGS-1. There is no arithmetic on data; words pass bit-exact.

Test Plan:
- Single core, out_ready=1:
  - Stimulus: N_CORES=2; drive core 0 regs r(i+1)=i+1, i.e. 1..16; raise core_done[0] at cycle 10.
  - Response: out_valid from cycle 12; out_data 1..16 on consecutive cycles with out_core=0 and out_idx 0..15; out_last only with data 16; busy returns low at cycle 28.
- Backpressure:
  - Stimulus: same as above, but out_ready toggles 1,0,0,1,...
  - Response: each word is held stable through stalls; exactly 16 accepted transfers, with no loss or duplication.
- Simultaneous done:
  - Stimulus: core 0 regs = 0x100+i and core 1 regs = 0x200+i; both core_done bits rise in the same cycle.
  - Response: the 16 core-0 words are followed by one idle cycle, then the 16 core-1 words; all_done rises one cycle after the last core-1 acceptance.
- Snapshot isolation:
  - Stimulus: change core_regs the cycle after capture.
  - Response: the streamed values are the captured ones.
- Overrun:
  - Stimulus: hold out_ready=0; pulse core_done[0] low then high again while core 0 is pending.
  - Response: overrun=1; the original data is streamed unchanged; no second dump occurs for core 0.
- Reset mid-stream:
  - Stimulus: assert rst_n low after the 5th word is accepted, then release.
  - Response: outputs are 0 during reset; after release, IDLE with no output until a fresh core_done rise; done held high across reset is not treated as a rise until it goes low and then high again.
